// File: rtl/urv_dm_wb_master_pkg.sv
// Shared types and constants for the uRV data-memory Wishbone master.
//   state_e    : FSM states (idle, strobe phase, waiting for response)
//   tmo_t      : watchdog timer type
//   word_align : forces a byte address onto a 32-bit word boundary
package urv_dm_wb_master_pkg;

    localparam int unsigned TmoW = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } state_e;

    typedef logic [TmoW-1:0] tmo_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/urv_dm_wb_master_if.sv
// Pipelined Wishbone B4 single-master bus bundle.
//   cyc, stb, we, adr, sel, dat_w : master -> slave
//   dat_r, ack, err, stall        : slave -> master
interface urv_dm_wb_master_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack, err, stall
    );

endinterface

// File: rtl/urv_dm_wb_master.sv
// Data-memory bus master for the uRV core: turns one-cycle load/store strobes into
// single-beat pipelined Wishbone cycles and reports completion to writeback.
// A watchdog ends any cycle that gets no ACK/ERR within g_timeout_cycles.
//   clk_i, rst_n_i   : clock, synchronous active-low reset
//   dm_*_i           : request from the core (address, store data, byte enables, strobes)
//   dm_ready_o       : idle, a strobe will be accepted
//   dm_data_l_o      : load data, updated on load completion and held
//   dm_*_done_o      : one-cycle completion pulses
//   dm_bus_err_o     : pulses with done when the cycle ended by ERR or timeout
//   wb               : Wishbone master port
module urv_dm_wb_master
    import urv_dm_wb_master_pkg::*;
#(
    parameter int unsigned g_timeout_cycles = 256,
    parameter logic [31:0] g_err_data       = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_bus_err_o,
    urv_dm_wb_master_if.master wb
);

    localparam tmo_t TmoLast = tmo_t'(g_timeout_cycles - 1);

    state_e      state_q;
    tmo_t        timer_q;
    logic        cyc_q;
    logic        stb_q;
    logic        we_q;
    logic [31:0] adr_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;
    logic        ready_q;
    logic [31:0] data_l_q;
    logic        load_done_q;
    logic        store_done_q;
    logic        bus_err_q;

    logic        finish;
    logic        fin_err;

    // ACK wins over the watchdog in the same cycle; ERR wins over ACK.
    assign finish  = wb.ack || wb.err || (timer_q == TmoLast);
    assign fin_err = wb.err || !wb.ack;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            sel_q        <= '0;
            dat_q        <= '0;
            ready_q      <= 1'b1;
            data_l_q     <= '0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            bus_err_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    timer_q <= '0;
                    // Store wins when both strobes arrive together.
                    if (dm_load_i || dm_store_i) begin
                        we_q    <= dm_store_i;
                        adr_q   <= word_align(dm_addr_i);
                        sel_q   <= dm_data_select_i;
                        dat_q   <= dm_data_s_i;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= StReq;
                    end
                end
                StReq, StWait: begin
                    timer_q <= timer_q + tmo_t'(1);
                    if (finish) begin
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        ready_q   <= 1'b1;
                        bus_err_q <= fin_err;
                        state_q   <= StIdle;
                        if (we_q) begin
                            store_done_q <= 1'b1;
                        end else begin
                            load_done_q <= 1'b1;
                            data_l_q    <= fin_err ? g_err_data : wb.dat_r;
                        end
                    end else if (state_q == StReq && !wb.stall) begin
                        stb_q   <= 1'b0;
                        state_q <= StWait;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wb.cyc          = cyc_q;
    assign wb.stb          = stb_q;
    assign wb.we           = we_q;
    assign wb.adr          = adr_q;
    assign wb.sel          = sel_q;
    assign wb.dat_w        = dat_q;
    assign dm_ready_o      = ready_q;
    assign dm_data_l_o     = data_l_q;
    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;
    assign dm_bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_urv_dm_wb_master.sv
// Self-checking bench for urv_dm_wb_master: table of transactions with a scripted
// slave, an expectation queue popped on each completion pulse, plus hand sequences
// for timeout with a late ACK and reset in the middle of a cycle.
module tb_urv_dm_wb_master;

    localparam int unsigned Tmo = 8;

    typedef enum int {KLoad, KStore, KBoth} kind_e;
    typedef enum int {RNone, RAck, RErr, RBoth} resp_e;

    typedef struct {
        kind_e       kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          stall_n;
        int          wait_n;
        resp_e       resp;
        logic [31:0] rdata;
        bit          poke;
        bit          b2b;
        logic [31:0] exp_adr;
        bit          exp_we;
        logic [31:0] exp_data_l;
        bit          exp_err;
        int          exp_lat;
        int          exp_stb;
    } vec_t;

    typedef struct {
        bit          we;
        logic [31:0] data_l;
        bit          err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dm_addr;
    logic [31:0] dm_data_s;
    logic [3:0]  dm_sel;
    logic        dm_load;
    logic        dm_store;
    logic        dm_ready;
    logic [31:0] dm_data_l;
    logic        dm_load_done;
    logic        dm_store_done;
    logic        dm_bus_err;

    urv_dm_wb_master_if wb_if ();

    urv_dm_wb_master #(
        .g_timeout_cycles (Tmo),
        .g_err_data       (32'hDEADBEEF)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .dm_addr_i        (dm_addr),
        .dm_data_s_i      (dm_data_s),
        .dm_data_select_i (dm_sel),
        .dm_load_i        (dm_load),
        .dm_store_i       (dm_store),
        .dm_ready_o       (dm_ready),
        .dm_data_l_o      (dm_data_l),
        .dm_load_done_o   (dm_load_done),
        .dm_store_done_o  (dm_store_done),
        .dm_bus_err_o     (dm_bus_err),
        .wb               (wb_if)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(kind_e kind, logic [31:0] addr, logic [31:0] wdata,
                                logic [3:0] sel, int stall_n, int wait_n, resp_e resp,
                                logic [31:0] rdata, bit poke, bit b2b,
                                logic [31:0] exp_adr, bit exp_we, logic [31:0] exp_data_l,
                                bit exp_err, int exp_lat, int exp_stb);
        vec_t v;
        v.kind = kind; v.addr = addr; v.wdata = wdata; v.sel = sel;
        v.stall_n = stall_n; v.wait_n = wait_n; v.resp = resp; v.rdata = rdata;
        v.poke = poke; v.b2b = b2b; v.exp_adr = exp_adr; v.exp_we = exp_we;
        v.exp_data_l = exp_data_l; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_stb = exp_stb;
        return v;
    endfunction

    // Called #1 after an edge with the master idle; returns #1 after the edge at
    // which the completion pulse became visible.
    task automatic run_txn(input vec_t v);
        exp_t e;
        exp_t got_e;
        int   c;
        int   stb_cnt;
        bit   got;
        chk("ready_before_req", dm_ready, 1);
        dm_addr   = v.addr;
        dm_data_s = v.wdata;
        dm_sel    = v.sel;
        dm_load   = (v.kind != KStore);
        dm_store  = (v.kind != KLoad);
        wb_if.dat_r = v.rdata;
        e.we = v.exp_we; e.data_l = v.exp_data_l; e.err = v.exp_err; e.lat = v.exp_lat;
        sb.push_back(e);
        step();
        dm_load  = 1'b0;
        dm_store = 1'b0;
        c = 0;
        stb_cnt = 0;
        got = 1'b0;
        while (!got && c < 40) begin
            if (dm_load_done || dm_store_done) begin
                got = 1'b1;
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                end else begin
                    got_e = sb.pop_front();
                    chk("latency", c, got_e.lat);
                    chk("store_done", dm_store_done, got_e.we);
                    chk("load_done", dm_load_done, !got_e.we);
                    chk("bus_err", dm_bus_err, got_e.err);
                    chk("data_l", dm_data_l, got_e.data_l);
                end
                chk("stb_cycles", stb_cnt, v.exp_stb);
                chk("cyc_after_done", wb_if.cyc, 0);
                chk("ready_at_done", dm_ready, 1);
            end else begin
                chk("cyc_busy", wb_if.cyc, 1);
                chk("ready_busy", dm_ready, 0);
                chk("adr", wb_if.adr, v.exp_adr);
                chk("we", wb_if.we, v.exp_we);
                chk("sel", wb_if.sel, v.sel);
                if (v.exp_we) chk("dat_w", wb_if.dat_w, v.wdata);
                if (wb_if.stb) stb_cnt++;
                wb_if.stall = (c < v.stall_n);
                wb_if.ack = (v.resp == RAck || v.resp == RBoth) && (c == v.stall_n + v.wait_n);
                wb_if.err = (v.resp == RErr || v.resp == RBoth) && (c == v.stall_n + v.wait_n);
                if (v.poke && c == 1) begin
                    dm_load = 1'b1;
                    dm_addr = 32'h0000_0FFC;
                end else begin
                    dm_load = 1'b0;
                end
                step();
                c++;
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: no completion after %0d cycles, expected one", c);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        wb_if.stall = 1'b0;
        wb_if.ack   = 1'b0;
        wb_if.err   = 1'b0;
        dm_load     = 1'b0;
    endtask

    task automatic idle_check(input logic [31:0] exp_data_l);
        step();
        chk("no_second_load_done", dm_load_done, 0);
        chk("no_second_store_done", dm_store_done, 0);
        chk("no_second_err", dm_bus_err, 0);
        chk("data_l_held", dm_data_l, exp_data_l);
        chk("idle_cyc", wb_if.cyc, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        dm_addr = '0; dm_data_s = '0; dm_sel = '0; dm_load = 1'b0; dm_store = 1'b0;
        wb_if.dat_r = '0; wb_if.ack = 1'b0; wb_if.err = 1'b0; wb_if.stall = 1'b0;

        vecs[0] = mk(KStore, 32'h100, 32'h12345678, 4'hF, 0, 0, RAck, 32'h0, 0, 0,
                     32'h100, 1, 32'h0, 0, 1, 1);
        vecs[1] = mk(KLoad, 32'h204, 32'h0, 4'hF, 3, 2, RAck, 32'hCAFEF00D, 1, 0,
                     32'h204, 0, 32'hCAFEF00D, 0, 6, 4);
        vecs[2] = mk(KLoad, 32'h302, 32'h0, 4'h3, 0, 1, RErr, 32'h11111111, 0, 0,
                     32'h300, 0, 32'hDEADBEEF, 1, 2, 1);
        vecs[3] = mk(KStore, 32'h40, 32'hA0A0B0B0, 4'h5, 1, 0, RErr, 32'h0, 0, 0,
                     32'h40, 1, 32'hDEADBEEF, 1, 2, 2);
        vecs[4] = mk(KLoad, 32'h80, 32'h0, 4'hF, 0, 3, RBoth, 32'h22222222, 0, 0,
                     32'h80, 0, 32'hDEADBEEF, 1, 4, 1);
        vecs[5] = mk(KLoad, 32'h84, 32'h0, 4'hF, 0, 0, RAck, 32'hA5A50001, 0, 1,
                     32'h84, 0, 32'hA5A50001, 0, 1, 1);
        vecs[6] = mk(KBoth, 32'h88, 32'h5555AAAA, 4'hF, 0, 0, RAck, 32'h33333333, 0, 1,
                     32'h88, 1, 32'hA5A50001, 0, 1, 1);
        vecs[7] = mk(KLoad, 32'h90, 32'h0, 4'hF, 2, 0, RNone, 32'h44444444, 0, 0,
                     32'h90, 0, 32'hDEADBEEF, 1, Tmo, 3);
        vecs[8] = mk(KLoad, 32'h94, 32'h0, 4'hF, 0, 6, RAck, 32'h00000077, 0, 0,
                     32'h94, 0, 32'h00000077, 0, 7, 1);
        vecs[9] = mk(KLoad, 32'h98, 32'h0, 4'hF, 0, 7, RAck, 32'h00000099, 0, 0,
                     32'h98, 0, 32'h00000099, 0, 8, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", dm_ready, 1);
        chk("rst_cyc", wb_if.cyc, 0);
        chk("rst_stb", wb_if.stb, 0);
        chk("rst_we", wb_if.we, 0);
        chk("rst_data_l", dm_data_l, 0);
        chk("rst_load_done", dm_load_done, 0);
        chk("rst_store_done", dm_store_done, 0);
        chk("rst_bus_err", dm_bus_err, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i]);
            if (!vecs[i].b2b) idle_check(vecs[i].exp_data_l);
        end

        // Timeout followed by a stale ACK that must be ignored.
        run_txn(mk(KLoad, 32'hA0, 32'h0, 4'hF, 0, 0, RNone, 32'h55555555, 0, 0,
                   32'hA0, 0, 32'hDEADBEEF, 1, Tmo, 1));
        step();
        step();
        wb_if.dat_r = 32'h12345678;
        wb_if.ack   = 1'b1;
        step();
        wb_if.ack = 1'b0;
        chk("late_ack_no_done", dm_load_done, 0);
        chk("late_ack_cyc", wb_if.cyc, 0);
        chk("late_ack_ready", dm_ready, 1);
        step();
        chk("late_ack_data_l", dm_data_l, 32'hDEADBEEF);
        chk("late_ack_no_done2", dm_load_done, 0);

        // Reset while waiting for the response.
        dm_addr = 32'hB0;
        dm_sel  = 4'hF;
        dm_load = 1'b1;
        step();
        dm_load = 1'b0;
        chk("pre_rst_stb", wb_if.stb, 1);
        step();
        step();
        chk("pre_rst_cyc", wb_if.cyc, 1);
        chk("pre_rst_stb_wait", wb_if.stb, 0);
        rst_n = 1'b0;
        step();
        chk("mid_rst_cyc", wb_if.cyc, 0);
        chk("mid_rst_ready", dm_ready, 1);
        chk("mid_rst_load_done", dm_load_done, 0);
        chk("mid_rst_bus_err", dm_bus_err, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_load_done", dm_load_done, 0);
        chk("post_rst_cyc", wb_if.cyc, 0);

        run_txn(mk(KStore, 32'hC1, 32'hFEEDFACE, 4'hC, 1, 1, RAck, 32'h0, 0, 0,
                   32'hC0, 1, 32'h0, 0, 3, 2));
        idle_check(32'h0);
        run_txn(mk(KLoad, 32'hC4, 32'h0, 4'hF, 0, 0, RAck, 32'h600DD00D, 0, 0,
                   32'hC4, 0, 32'h600DD00D, 0, 1, 1));
        idle_check(32'h600DD00D);

        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
